replayer: RTL and testbench

Address sequencer that replays a stored sequence at a fixed tick rate. On `start` it latches a length `limit` and rewinds to address 0. While `enable` is high, it issues one `read` strobe per tick with `addr` stepping 0..limit-1, then wraps. It sits between a sample/pattern memory (driven by `addr`/`read`) and the consumer that needs data at `TICK_PER_SEC`.

---
 rtl/replayer_pkg.sv | 18 +
 rtl/replayer_if.sv | 15 +
 rtl/replayer_tick.sv | 29 ++
 rtl/replayer.sv | 82 ++++++++
 tb/tb_replayer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/replayer_pkg.sv
// Shared types and helpers for the replayer address sequencer.
package replayer_pkg;

    localparam int ADDR_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Clocks per tick; a rate faster than the clock degenerates to a tick every cycle.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        int d;
        d = (tick_hz > 0) ? (clk_hz / tick_hz) : 1;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/replayer_if.sv
// Control and strobe bundle between the replayer and its controller/memory side.
interface replayer_if;
    import replayer_pkg::*;

    logic              start;
    logic              enable;
    logic [ADDR_W-1:0] limit;
    logic              read;
    logic              ready;
    logic [ADDR_W-1:0] addr;

    modport master (output start, enable, limit, input read, ready, addr);
    modport slave  (input start, enable, limit, output read, ready, addr);

endinterface

// File: rtl/replayer_tick.sv
// Prescaler: one-cycle tick every DIV enabled cycles; holds its count while disabled.
module replayer_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    assign tick = en && (pcnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clear) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/replayer.sv
// Replays addresses 0..len-1 at TICK_PER_SEC with a read strobe per tick.
// Define REPLAYER_ONESHOT_EN to stop after a single pass per start.
module replayer
    import replayer_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 12000000,
    parameter int TICK_PER_SEC  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    replayer_if.slave  bus
);

    localparam int DIV = calc_div(CLOCK_FREQ_HZ, TICK_PER_SEC);

    state_t            state;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              rdy;
    logic              run;
    logic              tick;
    logic              stop;
    logic              issue;
    logic [ADDR_W-1:0] nxt;
    logic              nxt_last;

    assign run = (state == ARMED) && bus.enable;

    replayer_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.start),
        .en    (run),
        .tick  (tick)
    );

`ifdef REPLAYER_ONESHOT_EN
    assign stop = rd && rdy;
`else
    assign stop = 1'b0;
`endif

    // Address shown by the next read: the one after the current read, or the held one.
    assign nxt      = rd ? ((addr == len - 1'b1) ? '0 : addr + 1'b1) : addr;
    assign nxt_last = (nxt == len - 1'b1);
    assign issue    = tick && !bus.start && !stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len   <= '0;
            addr  <= '0;
            rd    <= 1'b0;
            rdy   <= 1'b0;
        end else if (bus.start) begin
            len   <= bus.limit;
            addr  <= '0;
            rd    <= 1'b0;
            rdy   <= 1'b0;
            state <= (bus.limit != '0) ? ARMED : IDLE;
        end else begin
            rd  <= 1'b0;
            rdy <= 1'b0;
            if (stop) begin
                state <= IDLE;
                addr  <= '0;
            end else if (issue) begin
                rd   <= 1'b1;
                rdy  <= nxt_last;
                addr <= nxt;
            end else if (rd) begin
                addr <= nxt;
            end
        end
    end

    assign bus.read  = rd;
    assign bus.ready = rdy;
    assign bus.addr  = addr;

endmodule

// File: tb/tb_replayer.sv
// Scoreboard bench: stimulus queues expected reads (cycle, addr, ready); a monitor pops and compares.
module tb_replayer;

`ifdef REPLAYER_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic       ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   c0;
    exp_t q1[$];
    exp_t q4[$];

    replayer_if bus1 ();
    replayer_if bus4 ();

    // DIV clamps to 1 here
    replayer #(.CLOCK_FREQ_HZ(1), .TICK_PER_SEC(3)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    replayer #(.CLOCK_FREQ_HZ(4000), .TICK_PER_SEC(1000)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int d, input logic s, input logic e, input logic [7:0] l);
        if (d == 1) begin
            bus1.start = s; bus1.enable = e; bus1.limit = l;
        end else begin
            bus4.start = s; bus4.enable = e; bus4.limit = l;
        end
    endtask

    task automatic pushExp(input int d, input int c, input int a, input bit r);
        exp_t e;
        e.cyc   = c;
        e.addr  = a[7:0];
        e.ready = r;
        if (d == 1) q1.push_back(e);
        else        q4.push_back(e);
    endtask

    // n reads every period cycles from base; reads from index gapAt on are delayed by gap
    task automatic expectRun(input int d, input int base, input int period, input int n,
                             input int len, input int gapAt, input int gap);
        for (int k = 0; k < n; k++) begin
            if (!ONESHOT || k < len)
                pushExp(d, base + period * k + ((k >= gapAt) ? gap : 0), k % len, (k % len) == len - 1);
        end
    endtask

    task automatic monitorOne(input int d, input logic rd, input logic rdy, input logic [7:0] a);
        exp_t e;
        int   have;
        checkOutput($sformatf("u%0d_ready_without_read", d), int'(rdy && !rd), 0);
        if (rd) begin
            have = (d == 1) ? q1.size() : q4.size();
            checks++;
            if (have == 0) begin
                errors++;
                $display("[TB] FAIL u%0d_stray_read: read at cycle %0d addr=%0d, expected no read", d, cyc, a);
            end else begin
                e = (d == 1) ? q1.pop_front() : q4.pop_front();
                if (e.cyc != cyc || e.addr != a || e.ready != rdy) begin
                    errors++;
                    $display("[TB] FAIL u%0d_read: got cycle=%0d addr=%0d ready=%0d, expected cycle=%0d addr=%0d ready=%0d",
                             d, cyc, a, rdy, e.cyc, e.addr, e.ready);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            monitorOne(1, bus1.read, bus1.ready, bus1.addr);
            monitorOne(4, bus4.read, bus4.ready, bus4.addr);
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 8'd0);
        applyStimulus(4, 1'b0, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle_strobes_u1", int'(bus1.read | bus1.ready), 0);
            checkOutput("idle_strobes_u4", int'(bus4.read | bus4.ready), 0);
        end
        checkOutput("idle_addr_u1", int'(bus1.addr), 0);
        checkOutput("idle_addr_u4", int'(bus4.addr), 0);

        // DIV=1, limit=13, 100 enabled cycles: continuous reads, 7 ready pulses
        @(negedge clk);
        c0 = cyc;
        applyStimulus(1, 1'b1, 1'b0, 8'd13);
        expectRun(1, c0 + 2, 1, 100, 13, 1000, 0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 8'd13);
        repeat (100) @(negedge clk);
        applyStimulus(1, 1'b0, 1'b0, 8'd99);
        repeat (3) @(negedge clk);
        checkOutput("div1_paused_read", int'(bus1.read), 0);

        // DIV=4, limit=3, 10-cycle pause after the fifth read
        @(negedge clk);
        c0 = cyc;
        applyStimulus(4, 1'b1, 1'b0, 8'd3);
        expectRun(4, c0 + 5, 4, 9, 3, 5, 10);
        @(negedge clk);
        applyStimulus(4, 1'b0, 1'b1, 8'd3);
        repeat (22) @(negedge clk);
        applyStimulus(4, 1'b0, 1'b0, 8'd7);
        repeat (9) @(negedge clk);
        checkOutput("div4_pause_addr_hold", int'(bus4.addr), ONESHOT ? 0 : 2);
        checkOutput("div4_pause_read", int'(bus4.read), 0);
        @(negedge clk);
        applyStimulus(4, 1'b0, 1'b1, 8'd7);
        repeat (15) @(negedge clk);
        applyStimulus(4, 1'b0, 1'b0, 8'd7);

        // limit=0 never arms
        @(negedge clk);
        applyStimulus(1, 1'b1, 1'b1, 8'd0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 8'd0);
        repeat (20) @(negedge clk);
        checkOutput("limit0_read", int'(bus1.read), 0);
        checkOutput("limit0_addr", int'(bus1.addr), 0);

        // restart with limit=5 mid-run; the colliding tick is dropped
        @(negedge clk);
        c0 = cyc;
        applyStimulus(1, 1'b1, 1'b1, 8'd13);
        expectRun(1, c0 + 2, 1, 7, 13, 1000, 0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 8'd13);
        repeat (7) @(negedge clk);
        applyStimulus(1, 1'b1, 1'b1, 8'd5);
        expectRun(1, c0 + 10, 1, 12, 5, 1000, 0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 8'd5);
        repeat (12) @(negedge clk);
        applyStimulus(1, 1'b0, 1'b0, 8'd5);
        repeat (2) @(negedge clk);

        // limit=4 at DIV=1: one pass only when one-shot is built in
        @(negedge clk);
        c0 = cyc;
        applyStimulus(1, 1'b1, 1'b1, 8'd4);
        expectRun(1, c0 + 2, 1, 12, 4, 1000, 0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 8'd4);
        repeat (12) @(negedge clk);
        applyStimulus(1, 1'b0, 1'b0, 8'd4);
        repeat (2) @(negedge clk);

        // asynchronous reset mid-run clears everything
        @(negedge clk);
        c0 = cyc;
        applyStimulus(1, 1'b1, 1'b1, 8'd7);
        expectRun(1, c0 + 2, 1, 5, 7, 1000, 0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 8'd7);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_read", int'(bus1.read), 0);
        checkOutput("async_reset_addr", int'(bus1.addr), 0);
        checkOutput("async_reset_ready", int'(bus1.ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("after_reset_no_read", int'(bus1.read), 0);

        checkOutput("u1_pending_reads", q1.size(), 0);
        checkOutput("u4_pending_reads", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
